seq_pattern_ctrl: RTL and testbench
===================================

Name: seq_pattern_ctrl

Overview:
- Programmable controller for the serial Mealy sequence detector (x in, y out).
- Accepts a pattern configuration through a valid/ready handshake, then arms the detector on start.
- Tracks matches in overlapping or non-overlapping mode and sequences IDLE -> RUN -> DONE.
- Lets a host reuse one detector for any pattern up to MAX_LEN bits, e.g. "111" overlap.

Parameters:
- MAX_LEN, 8, longest supported pattern in bits (>=2).
- CNT_W, 8, width of match counter and match limit.
- TIMEOUT_BITS, 64, valid-bit budget without a match; used only with SPC_TIMEOUT_EN.
- Derived localparam LEN_W = clog2(MAX_LEN+1).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  controller accepts configuration (high only in IDLE)
- cfg_pattern  in  MAX_LEN  pattern; bit [cfg_len-1] is first received, bit [0] last
- cfg_len  in  LEN_W  pattern length, legal 2..MAX_LEN
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping
- cfg_max  in  CNT_W  matches before auto-DONE; 0 = unlimited
- start  in  1  one-cycle pulse, IDLE -> RUN
- stop  in  1  one-cycle pulse, RUN -> DONE
- x  in  1  serial data bit
- x_valid  in  1  x sampled this cycle
- y  out  1  Mealy match pulse, combinational from x/x_valid
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse on entry to DONE
- match_count  out  CNT_W  matches since last start
- timeout  out  1  sticky; set if the run ended by timeout

Behaviour:
- Reset: state IDLE. cfg_ready=1, busy=0, done=0, match_count=0, timeout=0, history and fill counter cleared. The configuration registers clear to len=0, overlap=0, max=0.
- Reset has priority over all inputs. Reset mid-RUN aborts the run and asserts no done.
- IDLE: on cfg_valid && cfg_ready, latch pattern/len/overlap/max.
  - An illegal cfg_len (<2 or >MAX_LEN) is still accepted but is clamped: <2 becomes 2, >MAX_LEN becomes MAX_LEN.
  - On start, go to RUN: clear history, fill and match_count, and clear timeout.
  - If cfg_valid and start occur in the same cycle, the new configuration applies to this run.
- RUN: cfg_ready=0 and busy=1. cfg_valid is ignored and no handshake completes.
  - Each cycle with x_valid=1, shift x into history at the LSB and increment fill, saturating at MAX_LEN.
  - y = x_valid && RUN && (fill >= len-1) && ({history[len-2:0], x} == pattern[len-1:0]). It is combinational in the same cycle x is presented, with zero latency.
  - x_valid=0 holds history and fill, and y=0.
  - On y: match_count increments, saturating at all-ones.
  - In non-overlap mode, fill resets to 0 on the match cycle so the next match needs len fresh bits. In overlap mode fill is kept.
  - If cfg_max != 0 and match_count+1 == cfg_max on a y cycle, go to DONE next cycle. This match is counted.
  - stop goes to DONE next cycle. If stop and the final match coincide, the match is counted and DONE is entered once.
  - start while in RUN is ignored.
- DONE: done=1 for exactly this one cycle. match_count holds. The next cycle returns to IDLE, with cfg_ready=1.
- match_count and timeout hold their values in IDLE until the next start.

Optional Feature:
- SPC_TIMEOUT_EN defined:
  - A bit counter counts x_valid cycles since start or since the last match.
  - When it reaches TIMEOUT_BITS with no y in that cycle, go to DONE and set timeout=1.
- Undefined: no counter; timeout is tied 0.

Test Plan:
- Overlap: cfg pattern=3'b111, len=3, overlap=1, max=0; start; x=0,1,1,1,1,0,0,1,1,1,0 (x_valid=1) -> y high on bits 4,5,10, match_count=3; stop -> done one cycle, then cfg_ready=1.
- Non-overlap: same stream, overlap=0 -> y on bits 4,10 only, match_count=2.
- Limit: overlap=1, max=2, same stream -> y on bits 4,5; done the cycle after bit 5; bit 10 gives y=0, busy=0, match_count=2.
- Gaps and handshake: pattern 4'b1011, len=4, x_valid toggled 1/0 between bits -> one match, with y only on a valid cycle. cfg_valid during RUN -> cfg_ready=0 and the configuration is unchanged after done.
- Reset mid-RUN after 2 matches -> next cycle IDLE, match_count=0, no done pulse. A following start with no new configuration runs with the configuration cleared to len=0, which clamps to 2, and pattern=0.
- With SPC_TIMEOUT_EN and TIMEOUT_BITS=8: pattern 111, stream of 8 zeros -> done after the 8th bit, timeout=1, match_count=0.

Source files
------------

// File: rtl/seq_pattern_ctrl.sv
// Programmable serial Mealy pattern detector: handshake-loaded pattern, IDLE -> RUN -> DONE sequencing.
// Defining SPC_TIMEOUT_EN adds a valid-bit budget that ends a run with no match after TIMEOUT_BITS bits.
module seq_pattern_ctrl #(
    parameter int unsigned MAX_LEN      = 8,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned TIMEOUT_BITS = 64,
    localparam int unsigned LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_max,
    input  logic               start,
    input  logic               stop,
    input  logic               x,
    input  logic               x_valid,
    output logic               y,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   match_count,
    output logic               timeout
);

    if (MAX_LEN < 2 || CNT_W < 1 || TIMEOUT_BITS < 1) begin : g_param_check
        $error("seq_pattern_ctrl: illegal parameter value");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overlap_q, overlap_d;
    logic [CNT_W-1:0]   max_q, max_d;
    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [LEN_W-1:0]   len_eff_c;
    logic [MAX_LEN-1:0] window_c;
    logic [MAX_LEN-1:0] mask_c;
    logic               match_c;
    logic               y_c;
    logic               hit_max_c;

`ifdef SPC_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_BITS + 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_flag_q, tmo_flag_d;
`endif

    // Illegal stored lengths (including the cleared value 0) are clamped at use
    always_comb begin
        len_eff_c = len_q;
        if (len_q < LEN_W'(2)) begin
            len_eff_c = LEN_W'(2);
        end else if (len_q > LEN_W'(MAX_LEN)) begin
            len_eff_c = LEN_W'(MAX_LEN);
        end
    end

    always_comb begin
        mask_c = '0;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            mask_c[i] = (LEN_W'(i) < len_eff_c);
        end
    end

    assign window_c  = {hist_q, x};
    assign match_c   = ((window_c ^ pattern_q) & mask_c) == '0;
    assign y_c       = x_valid && (state_q == S_RUN) &&
                       (fill_q >= (len_eff_c - LEN_W'(1))) && match_c;
    assign hit_max_c = y_c && (max_q != '0) && ((cnt_q + CNT_W'(1)) == max_q);

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        max_d     = max_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        cnt_d     = cnt_q;
`ifdef SPC_TIMEOUT_EN
        tmo_cnt_d  = tmo_cnt_q;
        tmo_flag_d = tmo_flag_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    pattern_d = cfg_pattern;
                    len_d     = cfg_len;
                    overlap_d = cfg_overlap;
                    max_d     = cfg_max;
                end
                if (start) begin
                    state_d = S_RUN;
                    hist_d  = '0;
                    fill_d  = '0;
                    cnt_d   = '0;
`ifdef SPC_TIMEOUT_EN
                    tmo_cnt_d  = '0;
                    tmo_flag_d = 1'b0;
`endif
                end
            end
            S_RUN: begin
                if (x_valid) begin
                    hist_d = window_c[MAX_LEN-2:0];
                    if (fill_q != LEN_W'(MAX_LEN)) begin
                        fill_d = fill_q + LEN_W'(1);
                    end
                end
                // Non-overlap restarts the fill so the next match needs len fresh bits
                if (y_c) begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (!overlap_q) begin
                        fill_d = '0;
                    end
                end
`ifdef SPC_TIMEOUT_EN
                if (x_valid) begin
                    if (y_c) begin
                        tmo_cnt_d = '0;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                        if (tmo_cnt_d == TMO_W'(TIMEOUT_BITS)) begin
                            state_d    = S_DONE;
                            tmo_flag_d = 1'b1;
                        end
                    end
                end
`endif
                if (stop || hit_max_c) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pattern_q <= '0;
            len_q     <= '0;
            overlap_q <= 1'b0;
            max_q     <= '0;
            hist_q    <= '0;
            fill_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            max_q     <= max_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef SPC_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_q  <= '0;
            tmo_flag_q <= 1'b0;
        end else begin
            tmo_cnt_q  <= tmo_cnt_d;
            tmo_flag_q <= tmo_flag_d;
        end
    end

    assign timeout = tmo_flag_q;
`else
    assign timeout = 1'b0;
`endif

    assign cfg_ready   = (state_q == S_IDLE);
    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign match_count = cnt_q;
    assign y           = y_c;

endmodule

// File: tb/tb_seq_pattern_ctrl.sv
// Scoreboard bench for seq_pattern_ctrl: directed scenarios plus randomized runs against a queue-based reference model.
module tb_seq_pattern_ctrl;

    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned CNT_W   = 8;
`ifdef SPC_TIMEOUT_EN
    localparam int unsigned TIMEOUT_BITS = 8;
`else
    localparam int unsigned TIMEOUT_BITS = 64;
`endif
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
    localparam int P_IDLE = 0, P_RUN = 1, P_DONE = 2;

    logic               clk = 1'b0;
    logic               reset, cfg_valid, cfg_ready, cfg_overlap, start, stop, x, x_valid;
    logic               y, busy, done, timeout;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic [CNT_W-1:0]   cfg_max, match_count;

    seq_pattern_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .TIMEOUT_BITS(TIMEOUT_BITS)) dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_max(cfg_max),
        .start(start), .stop(stop), .x(x), .x_valid(x_valid), .y(y), .busy(busy), .done(done),
        .match_count(match_count), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic             ready;
        logic             busy;
        logic             done;
        logic [CNT_W-1:0] cnt;
        logic             tmo;
        logic             y;
    } stat_t;

    typedef struct packed {
        int               cyc;
        logic [CNT_W-1:0] cnt;
        logic             tmo;
    } done_t;

    stat_t sq[$];
    int    yq[$];
    done_t dq[$];
    bit    mon_on = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: received bits kept as a queue, matches found by direct comparison
    int               m_ph = P_IDLE;
    logic [MAX_LEN-1:0] m_pat = '0;
    logic [LEN_W-1:0] m_len = '0;
    bit               m_ov = 1'b0;
    logic [CNT_W-1:0] m_max = '0;
    logic [CNT_W-1:0] m_cnt = '0;
    bit               m_tmo = 1'b0;
    int               m_since = 0;
    bit               bits[$];

    function automatic int eff_len(input logic [LEN_W-1:0] l);
        int li;
        li = int'(l);
        if (li < 2) return 2;
        if (li > int'(MAX_LEN)) return int'(MAX_LEN);
        return li;
    endfunction

    task automatic step(input bit rst, input bit cv, input bit st, input bit sp, input bit xv, input bit xb);
        bit    xv_e, ey, fin;
        int    len;
        bit    nbits[$];
        stat_t s;
        done_t d;
        xv_e = xv && !rst;
        reset = rst; cfg_valid = cv; start = st; stop = sp; x_valid = xv_e; x = xb;
        nbits = bits;
        ey = 1'b0;
        len = eff_len(m_len);
        if (m_ph == P_RUN && xv_e) begin
            nbits.push_back(xb);
            if (nbits.size() > int'(MAX_LEN)) void'(nbits.pop_front());
            if (nbits.size() >= len) begin
                ey = 1'b1;
                for (int k = 0; k < len; k++)
                    if (nbits[nbits.size() - 1 - k] != m_pat[k]) ey = 1'b0;
            end
        end
        s.ready = (m_ph == P_IDLE); s.busy = (m_ph == P_RUN); s.done = (m_ph == P_DONE);
        s.cnt = m_cnt; s.tmo = m_tmo; s.y = ey;
        sq.push_back(s);
        if (ey) yq.push_back(cyc);
        if (m_ph == P_DONE) begin
            d.cyc = cyc; d.cnt = m_cnt; d.tmo = m_tmo;
            dq.push_back(d);
        end
        if (rst) begin
            m_ph = P_IDLE; m_pat = '0; m_len = '0; m_ov = 1'b0; m_max = '0;
            m_cnt = '0; m_tmo = 1'b0; m_since = 0; nbits.delete();
        end else begin
            case (m_ph)
                P_IDLE: begin
                    if (cv) begin
                        m_pat = cfg_pattern; m_len = cfg_len; m_ov = cfg_overlap; m_max = cfg_max;
                    end
                    if (st) begin
                        m_ph = P_RUN; m_cnt = '0; m_tmo = 1'b0; m_since = 0; nbits.delete();
                    end
                end
                P_RUN: begin
                    fin = sp;
                    if (xv_e) begin
                        if (ey) begin
                            if (m_max != 0 && int'(m_cnt) + 1 == int'(m_max)) fin = 1'b1;
                            if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
                            if (!m_ov) nbits.delete();
                            m_since = 0;
                        end else begin
                            m_since++;
`ifdef SPC_TIMEOUT_EN
                            if (m_since == int'(TIMEOUT_BITS)) begin
                                fin = 1'b1; m_tmo = 1'b1;
                            end
`endif
                        end
                    end
                    if (fin) m_ph = P_DONE;
                end
                default: m_ph = P_IDLE;
            endcase
        end
        bits = nbits;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        stat_t s;
        done_t d;
        int    c;
        if (mon_on) begin
            if (sq.size() == 0) begin
                chk("status_queue_empty", 32'(sq.size()), 1);
            end else begin
                s = sq.pop_front();
                chk("cfg_ready", 32'(cfg_ready), 32'(s.ready));
                chk("busy", 32'(busy), 32'(s.busy));
                chk("done", 32'(done), 32'(s.done));
                chk("match_count", 32'(match_count), 32'(s.cnt));
                chk("timeout", 32'(timeout), 32'(s.tmo));
                chk("y", 32'(y), 32'(s.y));
            end
            if (y === 1'b1) begin
                if (yq.size() == 0) begin
                    chk("unexpected_y", 1, 0);
                end else begin
                    c = yq.pop_front();
                    chk("y_cycle", 32'(cyc), 32'(c));
                end
            end
            if (done === 1'b1) begin
                if (dq.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    d = dq.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(d.cyc));
                    chk("done_count", 32'(match_count), 32'(d.cnt));
                    chk("done_timeout", 32'(timeout), 32'(d.tmo));
                end
            end
        end
    end

    task automatic set_cfg(input logic [MAX_LEN-1:0] p, input int l, input bit ov, input int mx);
        cfg_pattern = p; cfg_len = LEN_W'(l); cfg_overlap = ov; cfg_max = CNT_W'(mx);
    endtask

    // Bits are sent MSB first; with gaps each valid bit is followed by an invalid cycle
    task automatic run_bits(input logic [31:0] s, input int n, input bit gaps);
        for (int i = n - 1; i >= 0; i--) begin
            step(0, 0, 0, 0, 1, s[i]);
            if (gaps) step(0, 0, 0, 0, 0, 1'($urandom));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [31:0] stream;
        reset = 1'b1; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0; x = 1'b0; x_valid = 1'b0;
        set_cfg('0, 0, 0, 0);
        @(posedge clk);
        #1;
        mon_on = 1'b1;
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 1);
        idle(1);

        stream = 32'b01111001110;
        // Overlapping "111"
        set_cfg(8'b111, 3, 1, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        run_bits(stream, 11, 0);
        step(0, 0, 0, 1, 0, 0);
        idle(2);

        // Non-overlapping "111"
        set_cfg(8'b111, 3, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        run_bits(stream, 11, 0);
        step(0, 0, 0, 1, 0, 0);
        idle(2);

        // Match limit of 2 ends the run early
        set_cfg(8'b111, 3, 1, 2);
        step(0, 1, 1, 0, 0, 0);
        run_bits(stream, 11, 0);
        step(0, 0, 0, 1, 0, 0);
        idle(2);

        // Gapped input, and a configuration offered during RUN must be ignored
        set_cfg(8'b1011, 4, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        stream = 32'b10110;
        run_bits(stream, 5, 1);
        set_cfg(8'b00, 2, 1, 1);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        idle(2);
        step(0, 0, 1, 0, 0, 0);
        stream = 32'b1011;
        run_bits(stream, 4, 1);
        step(0, 0, 0, 1, 0, 0);
        idle(2);

        // Reset mid-run, then start on the cleared configuration
        set_cfg(8'b111, 3, 1, 0);
        step(0, 1, 1, 0, 0, 0);
        stream = 32'b1111;
        run_bits(stream, 4, 0);
        step(1, 0, 0, 0, 0, 0);
        idle(2);
        step(0, 0, 1, 0, 0, 0);
        stream = 32'b0000;
        run_bits(stream, 4, 0);
        step(0, 0, 0, 1, 0, 0);
        idle(2);

`ifdef SPC_TIMEOUT_EN
        set_cfg(8'b111, 3, 1, 0);
        step(0, 1, 1, 0, 0, 0);
        stream = 32'h0;
        run_bits(stream, 8, 0);
        idle(3);
`endif

        // Randomized runs, including illegal lengths and stray control pulses
        for (int r = 0; r < 40; r++) begin
            int lenv;
            int n;
            bit same;
            lenv = ($urandom_range(0, 3) != 0) ? int'($urandom_range(2, 3)) : int'($urandom_range(0, 10));
            set_cfg(MAX_LEN'($urandom), lenv, 1'($urandom), int'($urandom_range(0, 3)));
            same = 1'($urandom);
            step(0, 1, same, 0, 0, 0);
            if (!same) step(0, 0, 1, 0, 0, 0);
            n = int'($urandom_range(10, 40));
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 4) == 0) set_cfg(MAX_LEN'($urandom), int'($urandom_range(0, 9)), 1'($urandom), 1);
                step($urandom_range(0, 150) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 12) == 0,
                     $urandom_range(0, 30) == 0, $urandom_range(0, 3) != 0, 1'($urandom));
            end
            step(0, 0, 0, 1, 0, 0);
            idle(2);
        end

        mon_on = 1'b0;
        chk("y_leftover", 32'(yq.size()), 0);
        chk("done_leftover", 32'(dq.size()), 0);
        chk("status_leftover", 32'(sq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
